skip_adder_sequencer: RTL and testbench

SKIP_ADDER_SEQUENCER -- requirements
Module: skip_adder_sequencer

---
 rtl/skip_adder_sequencer.sv | 121 ++++++++++++
 tb/tb_skip_adder_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/skip_adder_sequencer.sv
// Sequential carry-skip adder: one 4-bit ripple slice with skip logic is reused
// across N/4 slices, least-significant first, with the result reported on done.
module skip_adder_sequencer #(
    parameter int N = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [N-1:0]           A,
    input  logic [N-1:0]           B,
    output logic                   busy,
    output logic                   done,
    output logic [N-1:0]           Sum,
    output logic                   Cout,
    output logic                   Overflow,
    output logic [$clog2(N/4):0]   skip_cnt
);

    localparam int S  = N / 4;
    localparam int IW = (S > 1) ? $clog2(S) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic [IW-1:0] idx;
    logic          carry;

    logic [IW+1:0] base;
    logic [3:0]    a_k;
    logic [3:0]    b_k;
    logic [4:0]    ripple;
    logic          prop;
    logic          skip;
    logic          carry_next;
    logic          last;

    // Operand slice currently being added, selected by the slice index.
    assign base       = {idx, 2'b00};
    assign a_k        = a_reg[base +: 4];
    assign b_k        = b_reg[base +: 4];
    assign ripple     = {1'b0, a_k} + {1'b0, b_k} + {4'b0000, carry};
    assign prop       = &(a_k ^ b_k);
    assign skip       = prop & carry;
    assign carry_next = skip | ripple[4];
    assign last       = (idx == IW'(S - 1));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last)  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Results are only touched on an accepted start or while running, so they
    // stay stable from done until the next operation begins.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            Sum      <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
            skip_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg    <= A;
                        b_reg    <= B;
                        idx      <= '0;
                        carry    <= 1'b0;
                        Sum      <= '0;
                        Cout     <= 1'b0;
                        Overflow <= 1'b0;
                        skip_cnt <= '0;
                    end
                end
                RUN: begin
                    Sum[base +: 4] <= ripple[3:0];
                    carry          <= carry_next;
                    idx            <= idx + 1'b1;
                    if (skip) begin
                        skip_cnt <= skip_cnt + 1'b1;
                    end
                    // The top slice's sum bit 3 is the final sign bit of Sum.
                    if (last) begin
                        Cout     <= carry_next;
                        Overflow <= (a_reg[N-1] == b_reg[N-1]) && (ripple[3] != a_reg[N-1]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_skip_adder_sequencer.sv
// Scoreboard bench for skip_adder_sequencer: expected results are queued at start
// and compared when done is observed.
module tb_skip_adder_sequencer;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [N-1:0]  A;
    logic [N-1:0]  B;
    logic          busy;
    logic          done;
    logic [N-1:0]  Sum;
    logic          Cout;
    logic          Overflow;
    logic [3:0]    skip_cnt;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic [3:0]  skip;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    skip_adder_sequencer #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .Sum      (Sum),
        .Cout     (Cout),
        .Overflow (Overflow),
        .skip_cnt (skip_cnt)
    );

    always #5 clk = ~clk;

    // Reference: plain 33-bit addition, with per-slice carry-in recovered from the sum bits.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t       e;
        logic [3:0] x;
        logic       cin;
        {e.cout, e.sum} = {1'b0, a} + {1'b0, b};
        e.ovf  = (a[31] == b[31]) && (e.sum[31] != a[31]);
        e.skip = 4'd0;
        for (int k = 0; k < 8; k++) begin
            x   = a[4*k +: 4] ^ b[4*k +: 4];
            cin = e.sum[4*k] ^ a[4*k] ^ b[4*k];
            if ((&x) && cin) e.skip = e.skip + 4'd1;
        end
        return e;
    endfunction

    task automatic issue_start(input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic wait_done(input int first, output int edges, output bit seen);
        edges = first;
        seen  = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        A     = 32'hDEADBEEF;
        B     = 32'h01234567;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done); end
        total++; if (Sum !== 32'h0) begin bad++; $display("[TB] FAIL reset_sum got=%h want=0", Sum); end
        total++; if (Cout !== 1'b0 || Overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_flags got=%b%b want=00", Cout, Overflow); end
        total++; if (skip_cnt !== 4'd0) begin bad++; $display("[TB] FAIL reset_skip got=%0d want=0", skip_cnt); end
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_hold busy got=%b want=0", busy); end
    endtask

    task automatic test_vectors();
        logic [31:0] va [4];
        logic [31:0] vb [4];
        exp_t        ve [4];
        exp_t        e;
        int          edges;
        bit          seen;
        va = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h80000000};
        vb = '{32'h00000001, 32'h00000001, 32'h11111111, 32'h80000000};
        ve[0] = '{sum: 32'h80000000, cout: 1'b0, ovf: 1'b1, skip: 4'd6};
        ve[1] = '{sum: 32'h00000000, cout: 1'b1, ovf: 1'b0, skip: 4'd7};
        ve[2] = '{sum: 32'h23456789, cout: 1'b0, ovf: 1'b0, skip: 4'd0};
        ve[3] = '{sum: 32'h00000000, cout: 1'b1, ovf: 1'b1, skip: 4'd0};
        for (int v = 0; v < 4; v++) begin
            sb.push_back(ve[v]);
            issue_start(va[v], vb[v]);
            wait_done(1, edges, seen);
            total++; if (!seen || edges != 9) begin bad++; $display("[TB] FAIL vec%0d_latency got=%0d seen=%0b want=9", v, edges, seen); end
            if (sb.size() == 0) begin
                total++; bad++; $display("[TB] FAIL vec%0d_queue got=empty want=entry", v);
            end else begin
                e = sb.pop_front();
                total++; if (Sum !== e.sum) begin bad++; $display("[TB] FAIL vec%0d_sum got=%h want=%h", v, Sum, e.sum); end
                total++; if (Cout !== e.cout) begin bad++; $display("[TB] FAIL vec%0d_cout got=%b want=%b", v, Cout, e.cout); end
                total++; if (Overflow !== e.ovf) begin bad++; $display("[TB] FAIL vec%0d_ovf got=%b want=%b", v, Overflow, e.ovf); end
                total++; if (skip_cnt !== e.skip) begin bad++; $display("[TB] FAIL vec%0d_skip got=%0d want=%0d", v, skip_cnt, e.skip); end
                @(posedge clk);
                #1;
                total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL vec%0d_pulse done=%b busy=%b want=0 0", v, done, busy); end
                total++; if (Sum !== e.sum || Overflow !== e.ovf) begin bad++; $display("[TB] FAIL vec%0d_hold sum=%h ovf=%b want=%h %b", v, Sum, Overflow, e.sum, e.ovf); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
        int          edges;
        bit          seen;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0:       begin a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; end
                1:       begin a = 32'h0F0F0F0F; b = 32'hF0F0F0F1; end
                2:       begin a = 32'h00000000; b = 32'h00000000; end
                default: begin a = $urandom; b = $urandom; end
            endcase
            sb.push_back(model(a, b));
            issue_start(a, b);
            wait_done(1, edges, seen);
            total++; if (!seen || edges != 9) begin bad++; $display("[TB] FAIL b2b%0d_latency got=%0d seen=%0b want=9", i, edges, seen); end
            if (sb.size() == 0) begin
                total++; bad++; $display("[TB] FAIL b2b%0d_queue got=empty want=entry", i);
            end else begin
                e = sb.pop_front();
                total++;
                if (Sum !== e.sum || Cout !== e.cout || Overflow !== e.ovf || skip_cnt !== e.skip) begin
                    bad++;
                    $display("[TB] FAIL b2b%0d_result a=%h b=%h got=%h/%b/%b/%0d want=%h/%b/%b/%0d",
                             i, a, b, Sum, Cout, Overflow, skip_cnt, e.sum, e.cout, e.ovf, e.skip);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_start_during_run();
        exp_t e;
        int   edges;
        bit   seen;
        int   extra;
        sb.push_back(model(32'h7FFFFFFF, 32'h00000001));
        issue_start(32'h7FFFFFFF, 32'h00000001);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        A     = 32'h12345678;
        B     = 32'h11111111;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(4, edges, seen);
        total++; if (!seen || edges != 9) begin bad++; $display("[TB] FAIL ignore_latency got=%0d seen=%0b want=9", edges, seen); end
        e = sb.pop_front();
        total++;
        if (Sum !== e.sum || Cout !== e.cout || Overflow !== e.ovf || skip_cnt !== e.skip) begin
            bad++;
            $display("[TB] FAIL ignore_result got=%h/%b/%b/%0d want=%h/%b/%b/%0d",
                     Sum, Cout, Overflow, skip_cnt, e.sum, e.cout, e.ovf, e.skip);
        end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        total++; if (extra != 0) begin bad++; $display("[TB] FAIL ignore_single_done got=%0d active cycles want=0", extra); end
        total++; if (Sum !== e.sum || skip_cnt !== e.skip) begin bad++; $display("[TB] FAIL ignore_hold got=%h/%0d want=%h/%0d", Sum, skip_cnt, e.sum, e.skip); end
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        int   edges;
        bit   seen;
        int   extra;
        issue_start(32'h12345678, 32'h11111111);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL abort_ctrl busy=%b done=%b want=0 0", busy, done); end
        total++;
        if (Sum !== 32'h0 || Cout !== 1'b0 || Overflow !== 1'b0 || skip_cnt !== 4'd0) begin
            bad++;
            $display("[TB] FAIL abort_outputs got=%h/%b/%b/%0d want=0/0/0/0", Sum, Cout, Overflow, skip_cnt);
        end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        total++; if (extra != 0) begin bad++; $display("[TB] FAIL abort_no_done got=%0d active cycles want=0", extra); end

        sb.push_back(model(32'hFFFFFFFF, 32'h00000001));
        issue_start(32'hFFFFFFFF, 32'h00000001);
        wait_done(1, edges, seen);
        total++; if (!seen || edges != 9) begin bad++; $display("[TB] FAIL restart_latency got=%0d seen=%0b want=9", edges, seen); end
        e = sb.pop_front();
        total++;
        if (Sum !== e.sum || Cout !== e.cout || Overflow !== e.ovf || skip_cnt !== e.skip) begin
            bad++;
            $display("[TB] FAIL restart_result got=%h/%b/%b/%0d want=%h/%b/%b/%0d",
                     Sum, Cout, Overflow, skip_cnt, e.sum, e.cout, e.ovf, e.skip);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_start_during_run();
        test_reset_mid_run();
        total++; if (sb.size() != 0) begin bad++; $display("[TB] FAIL scoreboard_drain got=%0d left want=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
